// File: rtl/rom_boot_loader_if.sv
// ============================================================================
// Module : rom_boot_loader_if
// Brief  : Host boot-word handshake plus SRAM byte-write bus for the ROM loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface rom_boot_loader_if;
    logic [31:0] host_bootdata;
    logic        host_bootdata_req;
    logic        host_bootdata_ack;
    logic [7:0]  romwrite_data;
    logic [18:0] romwrite_addr;
    logic        romwrite_wr;
    logic        rom_initialised;

    modport master (
        output host_bootdata, host_bootdata_req,
        input  host_bootdata_ack, romwrite_data, romwrite_addr, romwrite_wr, rom_initialised
    );

    modport slave (
        input  host_bootdata, host_bootdata_req,
        output host_bootdata_ack, romwrite_data, romwrite_addr, romwrite_wr, rom_initialised
    );
endinterface

`default_nettype wire

// File: rtl/rom_boot_loader.sv
// ============================================================================
// Module : rom_boot_loader
// Brief  : Takes 32-bit ROM image words over a 4-phase req/ack and writes them
//          byte-wise into SRAM; flags rom_initialised once the image is complete.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rom_boot_loader #(
    parameter int          CONFIG_ON_STARTUP = 1,
    parameter logic [18:0] ROM_LOCATION      = 19'h5c000,
    parameter logic [18:0] ROM_BYTES         = 19'h08000,
    parameter int          WR_CYCLES         = 2
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    rom_boot_loader_if.slave bus
);

    localparam int c_WCW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    localparam logic [c_WCW-1:0] c_WR_LAST = c_WCW'(WR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_WRITE   = 3'd2,
        S_HOLD    = 3'd3,
        S_ACKWAIT = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_ack, w_ack_nxt;
    logic             r_wr, w_wr_nxt;
    logic             r_init, w_init_nxt;
    logic [31:0]      r_shift, w_shift_nxt;
    logic [18:0]      r_addr, w_addr_nxt;
    logic [18:0]      r_count, w_count_nxt;
    logic [1:0]       r_idx, w_idx_nxt;
    logic [c_WCW-1:0] r_wcnt, w_wcnt_nxt;

    wire logic w_req = bus.host_bootdata_req;

    // The byte on the bus is always the low byte of the shift register, so
    // data stays put from SETUP through HOLD and advances only on HOLD exit.
    assign bus.romwrite_data     = r_shift[7:0];
    assign bus.romwrite_addr     = r_addr;
    assign bus.romwrite_wr       = r_wr;
    assign bus.host_bootdata_ack = r_ack;
    assign bus.rom_initialised   = r_init;

    always_comb begin
        w_state_nxt = r_state;
        w_ack_nxt   = r_ack;
        w_wr_nxt    = 1'b0;
        w_init_nxt  = r_init;
        w_shift_nxt = r_shift;
        w_addr_nxt  = r_addr;
        w_count_nxt = r_count;
        w_idx_nxt   = r_idx;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (w_req && !r_ack) begin
                    w_shift_nxt = bus.host_bootdata;
                    w_ack_nxt   = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_wr_nxt    = 1'b1;
                w_wcnt_nxt  = c_WR_LAST;
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_wr_nxt   = 1'b1;
                    w_wcnt_nxt = r_wcnt - c_WCW'(1);
                end
            end
            S_HOLD: begin
                w_addr_nxt  = r_addr + 19'd1;
                w_count_nxt = r_count + 19'd1;
                w_shift_nxt = r_shift >> 8;
                w_idx_nxt   = r_idx + 2'd1;
                w_state_nxt = (r_idx == 2'd3) ? S_ACKWAIT : S_SETUP;
            end
            S_ACKWAIT: begin
                // Ack only drops once req is seen low, enforcing the 4-phase return.
                if (!w_req) begin
                    w_ack_nxt = 1'b0;
                    if (r_count == ROM_BYTES) begin
                        w_state_nxt = S_DONE;
                        w_init_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                if (w_req && !r_ack) begin
                    w_ack_nxt = 1'b1;
                end else if (!w_req && r_ack) begin
                    w_ack_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= (CONFIG_ON_STARTUP != 0) ? S_IDLE : S_DONE;
            r_init  <= (CONFIG_ON_STARTUP != 0) ? 1'b0 : 1'b1;
            r_ack   <= 1'b0;
            r_wr    <= 1'b0;
            r_shift <= 32'h0;
            r_addr  <= ROM_LOCATION;
            r_count <= 19'd0;
            r_idx   <= 2'd0;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_init  <= w_init_nxt;
            r_ack   <= w_ack_nxt;
            r_wr    <= w_wr_nxt;
            r_shift <= w_shift_nxt;
            r_addr  <= w_addr_nxt;
            r_count <= w_count_nxt;
            r_idx   <= w_idx_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rom_boot_loader.sv
// ============================================================================
// Module : tb_rom_boot_loader
// Brief  : Four loader instances (default, no-config, WR_CYCLES=1, =4) driven by
//          a vector table plus hand sequences for hold-req and mid-image reset.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rom_boot_loader;

    logic        clk = 1'b0;
    logic [3:0]  rst_n = 4'h0;
    logic [31:0] h_data [4];
    logic [3:0]  h_req = 4'h0;
    wire  [3:0]  w_ack, w_wr, w_init;
    wire  [18:0] w_addr [4];
    wire  [7:0]  w_dat  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rom_boot_loader_if bus();
        assign bus.host_bootdata     = h_data[g];
        assign bus.host_bootdata_req = h_req[g];
        assign w_ack[g]  = bus.host_bootdata_ack;
        assign w_wr[g]   = bus.romwrite_wr;
        assign w_init[g] = bus.rom_initialised;
        assign w_addr[g] = bus.romwrite_addr;
        assign w_dat[g]  = bus.romwrite_data;

        rom_boot_loader #(
            .CONFIG_ON_STARTUP(g == 1 ? 0 : 1),
            .ROM_LOCATION     (19'h5c000),
            .ROM_BYTES        (19'h00008),
            .WR_CYCLES        (g == 2 ? 1 : (g == 3 ? 4 : 2))
        ) u_dut (
            .clk    (clk),
            .reset_n(rst_n[g]),
            .bus    (bus.slave)
        );
    end

    // Write monitor: logs each wr pulse, its length, spacing and bus stability.
    int          cyc = 0;
    int          wn[4], run[4], last_run[4], per[4], rise[4], stab[4];
    logic [18:0] wl_addr [4][64];
    logic [7:0]  wl_data [4][64];
    logic [3:0]  p_wr = 4'h0;
    logic [18:0] p_addr [4];
    logic [7:0]  p_dat  [4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            p_wr[k]   <= w_wr[k];
            p_addr[k] <= w_addr[k];
            p_dat[k]  <= w_dat[k];
            if (w_wr[k] && !p_wr[k]) begin
                if (wn[k] < 64) begin
                    wl_addr[k][wn[k]] <= w_addr[k];
                    wl_data[k][wn[k]] <= w_dat[k];
                end
                wn[k]   <= wn[k] + 1;
                run[k]  <= 1;
                per[k]  <= cyc - rise[k];
                rise[k] <= cyc;
                if (w_addr[k] != p_addr[k] || w_dat[k] != p_dat[k]) stab[k] <= stab[k] + 1;
            end else if (w_wr[k]) begin
                run[k] <= run[k] + 1;
                if (w_addr[k] != p_addr[k] || w_dat[k] != p_dat[k]) stab[k] <= stab[k] + 1;
            end else if (p_wr[k]) begin
                last_run[k] <= run[k];
                if (w_addr[k] != p_addr[k] || w_dat[k] != p_dat[k]) stab[k] <= stab[k] + 1;
            end
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic req_up(input int d, input logic [31:0] word);
        int n = 0;
        @(negedge clk);
        h_data[d] = word;
        h_req[d]  = 1'b1;
        while (!w_ack[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ack_rise[%0d]", d), {31'h0, w_ack[d]}, 32'h1);
    endtask

    task automatic req_down(input int d);
        int n = 0;
        @(negedge clk);
        h_req[d] = 1'b0;
        while (w_ack[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ack_fall[%0d]", d), {31'h0, w_ack[d]}, 32'h0);
        repeat (3) @(negedge clk);
        #1;
    endtask

    typedef struct {
        int          d;
        logic [31:0] word;
        int          nwr;
        logic [18:0] addr;
        logic        init_pre;
        logic        init_post;
        int          len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int base, sb, n;
        vec_t v;

        vecs[0] = '{0, 32'h44332211, 4, 19'h5c000, 1'b0, 1'b0, 2};
        vecs[1] = '{0, 32'h88776655, 4, 19'h5c004, 1'b0, 1'b1, 2};
        vecs[2] = '{0, 32'hCAFEF00D, 0, 19'h5c000, 1'b1, 1'b1, 0};
        vecs[3] = '{1, 32'hDEADBEEF, 0, 19'h5c000, 1'b1, 1'b1, 0};
        vecs[4] = '{2, 32'h04030201, 4, 19'h5c000, 1'b0, 1'b0, 1};
        vecs[5] = '{3, 32'h0A0B0C0D, 4, 19'h5c000, 1'b0, 1'b0, 4};
        for (int k = 0; k < 4; k++) h_data[k] = 32'h0;

        repeat (3) @(negedge clk);
        rst_n = 4'hF;
        @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_ack[%0d]", k),  {31'h0, w_ack[k]}, 32'h0);
            check($sformatf("rst_wr[%0d]", k),   {31'h0, w_wr[k]}, 32'h0);
            check($sformatf("rst_data[%0d]", k), {24'h0, w_dat[k]}, 32'h0);
            check($sformatf("rst_addr[%0d]", k), {13'h0, w_addr[k]}, 32'h5c000);
            check($sformatf("rst_init[%0d]", k), {31'h0, w_init[k]}, (k == 1) ? 32'h1 : 32'h0);
        end

        for (int i = 0; i < 6; i++) begin
            v    = vecs[i];
            base = wn[v.d];
            sb   = stab[v.d];
            req_up(v.d, v.word);
            repeat (40) @(negedge clk);
            #1;
            check($sformatf("v%0d_ack_held", i), {31'h0, w_ack[v.d]}, 32'h1);
            check($sformatf("v%0d_init_pre", i), {31'h0, w_init[v.d]}, {31'h0, v.init_pre});
            req_down(v.d);
            check($sformatf("v%0d_init_post", i), {31'h0, w_init[v.d]}, {31'h0, v.init_post});
            check($sformatf("v%0d_nwr", i), wn[v.d] - base, v.nwr);
            check($sformatf("v%0d_stable", i), stab[v.d] - sb, 0);
            if (v.nwr == 4) begin
                for (int b = 0; b < 4; b++) begin
                    check($sformatf("v%0d_addr%0d", i, b), {13'h0, wl_addr[v.d][base+b]},
                          {13'h0, v.addr + 19'(b)});
                    check($sformatf("v%0d_data%0d", i, b), {24'h0, wl_data[v.d][base+b]},
                          {24'h0, v.word[8*b +: 8]});
                end
                check($sformatf("v%0d_wrlen", i), last_run[v.d], v.len);
                check($sformatf("v%0d_period", i), per[v.d], v.len + 2);
            end
        end

        // req held high across the whole word: exactly one capture.
        base = wn[3];
        req_up(3, 32'h77665544);
        repeat (60) @(negedge clk);
        #1;
        check("hold_nwr", wn[3] - base, 4);
        check("hold_ack", {31'h0, w_ack[3]}, 32'h1);
        check("hold_addr0", {13'h0, wl_addr[3][base]}, 32'h5c004);
        req_down(3);
        repeat (10) @(negedge clk);
        #1;
        check("hold_nwr_after", wn[3] - base, 4);

        // Reset during the third byte of the second word.
        @(negedge clk);
        rst_n[0] = 1'b0;
        @(negedge clk);
        rst_n[0] = 1'b1;
        #1;
        check("rr_init", {31'h0, w_init[0]}, 32'h0);
        check("rr_addr", {13'h0, w_addr[0]}, 32'h5c000);
        req_up(0, 32'h11111111);
        repeat (40) @(negedge clk);
        req_down(0);
        base = wn[0];
        req_up(0, 32'h55667788);
        n = 0;
        while (wn[0] < base + 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rr_third_byte", wn[0] - base, 3);
        #2;
        check("rr_wr_before", {31'h0, w_wr[0]}, 32'h1);
        rst_n[0] = 1'b0;
        #1;
        check("rr_wr_abort", {31'h0, w_wr[0]}, 32'h0);
        check("rr_ack_abort", {31'h0, w_ack[0]}, 32'h0);
        check("rr_init_abort", {31'h0, w_init[0]}, 32'h0);
        @(negedge clk);
        h_req[0] = 1'b0;
        rst_n[0] = 1'b1;
        repeat (2) @(negedge clk);
        base = wn[0];
        req_up(0, 32'h0BADF00D);
        repeat (40) @(negedge clk);
        req_down(0);
        check("rr_restart_nwr", wn[0] - base, 4);
        check("rr_restart_addr", {13'h0, wl_addr[0][base]}, 32'h5c000);
        check("rr_restart_data", {24'h0, wl_data[0][base]}, 32'h0D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire
